mem_stage: RTL and testbench

//  MEM pipeline stage, between EXE and WB. Holds one instruction and waits for its data-SRAM response.

---
 rtl/mem_stage_pkg.sv | 63 ++++++
 rtl/mem_load_align.sv | 65 ++++++
 rtl/mem_stage.sv | 154 +++++++++++++++
 tb/tb_mem_stage.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage_pkg
// Purpose : Shared bus widths, load-operation codes and bus layouts used by
//           the MEM pipeline stage and its load-alignment datapath.
// Contents: ES_TO_MS_BUS_WD / MS_TO_WS_BUS_WD / MS_EX_BUS_WD widths,
//           ld_op_t load encoding, es_to_ms_t and ms_ex_t packed bus layouts,
//           byte/half extension helpers.
// Revision: 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

   localparam int ES_TO_MS_BUS_WD = 77;
   localparam int MS_TO_WS_BUS_WD = 73;
   localparam int MS_EX_BUS_WD    = 47;

   typedef enum logic [2:0] {
      LD_NONE = 3'd0,
      LD_LB   = 3'd1,
      LD_LBU  = 3'd2,
      LD_LH   = 3'd3,
      LD_LHU  = 3'd4,
      LD_LW   = 3'd5,
      LD_LWL  = 3'd6,
      LD_LWR  = 3'd7
   } ld_op_t;

   // {ld_op[3],mem_req,gr_we[4],dest[5],alu_result[32],pc[32]}
   typedef struct packed {
      ld_op_t      ld_op;
      logic        mem_req;
      logic [3:0]  gr_we;
      logic [4:0]  dest;
      logic [31:0] alu_result;
      logic [31:0] pc;
   } es_to_ms_t;

   // {bd,sys,mfc0,mtc0,eret,break,ov,adel,ades,ri,c0_addr[5],badvaddr[32]}
   typedef struct packed {
      logic        bd;
      logic        sys;
      logic        mfc0;
      logic        mtc0;
      logic        eret;
      logic        brk;
      logic        ov;
      logic        adel;
      logic        ades;
      logic        ri;
      logic [4:0]  c0_addr;
      logic [31:0] badvaddr;
   } ms_ex_t;

   function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sign);
      return {{24{sign & b[7]}}, b};
   endfunction

   function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sign);
      return {{16{sign & h[15]}}, h};
   endfunction

endpackage : mem_stage_pkg
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
// Module  : mem_load_align
// Purpose : Combinational load-data alignment and register write-enable
//           generation for LB/LBU/LH/LHU/LW/LWL/LWR.
// Ports   : i_ld_op    load operation code
//           i_addr     low two address bits of the access
//           i_rdata    raw memory word
//           i_gr_we    write enables carried from EXE
//           o_gr_we    per-byte register write enables
//           o_result   aligned load data (meaningful for loads only)
// Revision: 1.0 - initial release
// ============================================================================
module mem_load_align
   import mem_stage_pkg::*;
(
   input  ld_op_t      i_ld_op,
   input  logic [1:0]  i_addr,
   input  logic [31:0] i_rdata,
   input  logic [3:0]  i_gr_we,
   output logic [3:0]  o_gr_we,
   output logic [31:0] o_result
);

   logic [31:0] w_shr;     // m >> 8*a : byte a lands in [7:0], also the LWR value
   logic [31:0] w_shl;     // m << 8*(3-a) : the LWL value
   logic [15:0] w_half;

   assign w_shr  = i_rdata >> {i_addr, 3'b000};
   assign w_shl  = i_rdata << {~i_addr, 3'b000};
   assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

   always_comb begin
      o_gr_we  = i_gr_we;
      o_result = i_rdata;
      case (i_ld_op)
         LD_LB  : o_result = ext_byte(w_shr[7:0], 1'b1);
         LD_LBU : o_result = ext_byte(w_shr[7:0], 1'b0);
         LD_LH  : o_result = ext_half(w_half, 1'b1);
         LD_LHU : o_result = ext_half(w_half, 1'b0);
         LD_LW  : o_result = i_rdata;
         LD_LWL : begin
            o_result = w_shl;
            case (i_addr)
               2'd0    : o_gr_we = 4'b1000;
               2'd1    : o_gr_we = 4'b1100;
               2'd2    : o_gr_we = 4'b1110;
               default : o_gr_we = 4'b1111;
            endcase
         end
         LD_LWR : begin
            o_result = w_shr;
            case (i_addr)
               2'd0    : o_gr_we = 4'b1111;
               2'd1    : o_gr_we = 4'b0111;
               2'd2    : o_gr_we = 4'b0011;
               default : o_gr_we = 4'b0001;
            endcase
         end
         default : o_result = i_rdata;
      endcase
   end

endmodule : mem_load_align
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage
// Purpose : MEM pipeline stage between EXE and WB. Holds one instruction,
//           waits for its data-SRAM response, aligns load data, and forwards
//           the result plus a pass-through exception bus to WB. Exposes
//           hazard/bypass information to ID/EXE.
// Ports   : clk, reset          clock, synchronous active-high reset
//           flush               CP0 exception/eret flush
//           es_to_ms_valid/bus  instruction from EXE, es_ex_bus its exceptions
//           ms_allowin          MEM can accept from EXE
//           ws_allowin          WB can accept
//           ms_to_ws_valid/bus  instruction offered to WB, ms_ex_bus exceptions
//           data_sram_data_ok   response strobe, data_sram_rdata load data
//           ms_ex, ms_write_reg, ms_reg_dest, ms_fwd_data, ms_data_pending
//                               hazard and forwarding info
// Revision: 1.0 - initial release
// ============================================================================
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int CANCEL_W = 2
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   input  logic [MS_EX_BUS_WD-1:0]    es_ex_bus,
   output logic                       ms_allowin,
   input  logic                       ws_allowin,
   output logic                       ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   output logic [MS_EX_BUS_WD-1:0]    ms_ex_bus,
   input  logic                       data_sram_data_ok,
   input  logic [31:0]                data_sram_rdata,
   output logic                       ms_ex,
   output logic                       ms_write_reg,
   output logic [4:0]                 ms_reg_dest,
   output logic [31:0]                ms_fwd_data,
   output logic                       ms_data_pending
);

   localparam logic [CANCEL_W-1:0] c_cancel_one = {{(CANCEL_W-1){1'b0}}, 1'b1};
   localparam logic [CANCEL_W-1:0] c_cancel_max = '1;

   es_to_ms_t           r_es;
   ms_ex_t              r_ex;
   logic                r_ms_valid;
   logic                r_buf_valid;
   logic [31:0]         r_buf_data;
   logic [CANCEL_W-1:0] r_cancel_cnt;

   logic        w_cancel_idle;
   logic        w_data_accept;
   logic        w_ready_go;
   logic        w_leave;
   logic        w_buf_capture;
   logic        w_cancel_inc;
   logic        w_cancel_dec;
   logic [31:0] w_mem_word;
   logic [3:0]  w_gr_we;
   logic [31:0] w_align_result;
   logic [31:0] w_final;

   // A response only belongs to the current instruction once every response
   // still owed to flushed requests has drained.
   assign w_cancel_idle = (r_cancel_cnt == '0);
   assign w_data_accept = data_sram_data_ok & w_cancel_idle;
   assign w_ready_go    = ~r_es.mem_req | r_buf_valid | w_data_accept;

   assign ms_allowin     = ~r_ms_valid | (w_ready_go & ws_allowin);
   assign ms_to_ws_valid = r_ms_valid & w_ready_go & ~flush;
   assign w_leave        = ms_to_ws_valid & ws_allowin;

   // The SRAM presents data for one cycle only; park it if WB is stalled.
   assign w_buf_capture = r_ms_valid & r_es.mem_req & ~r_buf_valid
                        & w_data_accept & ~ws_allowin;

   // A flushed request whose response has not yet arrived still owes one.
   // If the response arrives in the flush cycle itself it is consumed there.
   assign w_cancel_inc = flush & r_ms_valid & r_es.mem_req & ~r_buf_valid
                       & ~data_sram_data_ok;
   assign w_cancel_dec = data_sram_data_ok & ~w_cancel_idle;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_ms_valid <= 1'b0;
      end else if (ms_allowin) begin
         r_ms_valid <= es_to_ms_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (es_to_ms_valid && ms_allowin) begin
         r_es <= es_to_ms_t'(es_to_ms_bus);
         r_ex <= ms_ex_t'(es_ex_bus);
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush || w_leave) begin
         r_buf_valid <= 1'b0;
      end else if (w_buf_capture) begin
         r_buf_valid <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_buf_capture) begin
         r_buf_data <= data_sram_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cancel_cnt <= '0;
      end else if (w_cancel_inc) begin
         if (r_cancel_cnt != c_cancel_max) begin
            r_cancel_cnt <= r_cancel_cnt + c_cancel_one;
         end
      end else if (w_cancel_dec) begin
         r_cancel_cnt <= r_cancel_cnt - c_cancel_one;
      end
   end

   a_cancel_no_overflow : assert property (@(posedge clk) disable iff (reset)
      !(w_cancel_inc && (r_cancel_cnt == c_cancel_max)));

   assign w_mem_word = r_buf_valid ? r_buf_data : data_sram_rdata;

   mem_load_align u_align (
      .i_ld_op  (r_es.ld_op),
      .i_addr   (r_es.alu_result[1:0]),
      .i_rdata  (w_mem_word),
      .i_gr_we  (r_es.gr_we),
      .o_gr_we  (w_gr_we),
      .o_result (w_align_result)
   );

   assign w_final = (r_es.ld_op == LD_NONE) ? r_es.alu_result : w_align_result;

   assign ms_to_ws_bus = {w_gr_we, r_es.dest, w_final, r_es.pc};
   assign ms_ex_bus    = r_ex;

   assign ms_ex = r_ms_valid & (r_ex.eret | r_ex.sys | r_ex.brk | r_ex.ov
                              | r_ex.adel | r_ex.ades | r_ex.ri);
   assign ms_write_reg    = r_ms_valid & (|w_gr_we);
   assign ms_reg_dest     = r_es.dest;
   assign ms_fwd_data     = w_final;
   assign ms_data_pending = r_ms_valid & (r_es.ld_op != LD_NONE) & ~w_ready_go;

endmodule : mem_stage
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_stage
// Purpose : Self-checking bench for mem_stage. Directed stimulus pushes the
//           expected WB transfer into a scoreboard; a monitor pops and
//           compares whenever MEM hands an instruction to WB.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic                       clk;
   logic                       reset;
   logic                       flush;
   logic                       es_to_ms_valid;
   logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
   logic [MS_EX_BUS_WD-1:0]    es_ex_bus;
   logic                       ms_allowin;
   logic                       ws_allowin;
   logic                       ms_to_ws_valid;
   logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
   logic [MS_EX_BUS_WD-1:0]    ms_ex_bus;
   logic                       data_sram_data_ok;
   logic [31:0]                data_sram_rdata;
   logic                       ms_ex;
   logic                       ms_write_reg;
   logic [4:0]                 ms_reg_dest;
   logic [31:0]                ms_fwd_data;
   logic                       ms_data_pending;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] pc_ctr = 32'hBFC0_0000;

   logic [MS_TO_WS_BUS_WD-1:0] exp_ws_q[$];
   logic [MS_EX_BUS_WD-1:0]    exp_ex_q[$];

   mem_stage #(.CANCEL_W(2)) dut (
      .clk               (clk),
      .reset             (reset),
      .flush             (flush),
      .es_to_ms_valid    (es_to_ms_valid),
      .es_to_ms_bus      (es_to_ms_bus),
      .es_ex_bus         (es_ex_bus),
      .ms_allowin        (ms_allowin),
      .ws_allowin        (ws_allowin),
      .ms_to_ws_valid    (ms_to_ws_valid),
      .ms_to_ws_bus      (ms_to_ws_bus),
      .ms_ex_bus         (ms_ex_bus),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .ms_ex             (ms_ex),
      .ms_write_reg      (ms_write_reg),
      .ms_reg_dest       (ms_reg_dest),
      .ms_fwd_data       (ms_fwd_data),
      .ms_data_pending   (ms_data_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [ES_TO_MS_BUS_WD-1:0] mk_es(input logic [2:0] op, input logic mreq,
         input logic [3:0] we, input logic [4:0] dest, input logic [31:0] alu, input logic [31:0] pc);
      return {op, mreq, we, dest, alu, pc};
   endfunction

   function automatic logic [MS_TO_WS_BUS_WD-1:0] mk_ws(input logic [3:0] we, input logic [4:0] dest,
         input logic [31:0] res, input logic [31:0] pc);
      return {we, dest, res, pc};
   endfunction

   // Scoreboard monitor: sample mid-cycle, a transfer happens on the next edge.
   always @(negedge clk) begin
      if (!reset && ms_to_ws_valid && ws_allowin) begin
         if (exp_ws_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_ws_transfer: got %0h expected none", ms_to_ws_bus);
         end else begin
            chk("ws_bus", 128'(ms_to_ws_bus), 128'(exp_ws_q.pop_front()));
            chk("ws_ex_bus", 128'(ms_ex_bus), 128'(exp_ex_q.pop_front()));
         end
      end
   end

   // Issue one instruction into an empty MEM with WB ready; when a memory
   // request is made the response comes in the cycle after entry.
   task automatic run_load(input string name, input logic [2:0] op, input logic mreq,
         input logic [3:0] we_in, input logic [4:0] dest, input logic [31:0] alu,
         input logic [31:0] rdata, input logic [3:0] exp_we, input logic [31:0] exp_res);
      pc_ctr = pc_ctr + 32'd4;
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk_es(op, mreq, we_in, dest, alu, pc_ctr);
      exp_ws_q.push_back(mk_ws(exp_we, dest, exp_res, pc_ctr));
      exp_ex_q.push_back('0);
      step();
      es_to_ms_valid = 1'b0;
      if (mreq) begin
         #1;
         chk({name, "_pending"}, 128'(ms_data_pending), 128'(op != 3'd0));
         data_sram_data_ok = 1'b1;
         data_sram_rdata   = rdata;
      end
      step();
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = 32'hDEAD_0000;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;  flush = 1'b0;  es_to_ms_valid = 1'b0;
      es_to_ms_bus = '0;  es_ex_bus = '0;  ws_allowin = 1'b1;
      data_sram_data_ok = 1'b0;  data_sram_rdata = '0;
      step();
      step();
      chk("reset_to_ws_valid", 128'(ms_to_ws_valid), 128'(0));
      chk("reset_allowin", 128'(ms_allowin), 128'(1));
      chk("reset_ms_ex", 128'(ms_ex), 128'(0));
      chk("reset_write_reg", 128'(ms_write_reg), 128'(0));
      chk("reset_pending", 128'(ms_data_pending), 128'(0));
      reset = 1'b0;
      step();

      // LB byte 1 of 0x123480FF = 0x80, sign-extended
      run_load("lb", LD_LB, 1'b1, 4'b1111, 5'd3, 32'h0000_1001, 32'h1234_80FF, 4'b1111, 32'hFFFF_FF80);
      run_load("lwr", LD_LWR, 1'b1, 4'b1111, 5'd4, 32'h0000_2002, 32'hAABB_CCDD, 4'b0011, 32'h0000_AABB);
      run_load("lwl", LD_LWL, 1'b1, 4'b1111, 5'd5, 32'h0000_3001, 32'hAABB_CCDD, 4'b1100, 32'hCCDD_0000);
      run_load("lhu", LD_LHU, 1'b1, 4'b1111, 5'd6, 32'h0000_3002, 32'h8001_7FFF, 4'b1111, 32'h0000_8001);
      run_load("lh", LD_LH, 1'b1, 4'b1111, 5'd7, 32'h0000_3000, 32'h1234_8765, 4'b1111, 32'hFFFF_8765);
      run_load("lbu", LD_LBU, 1'b1, 4'b1111, 5'd8, 32'h0000_3003, 32'h9ABC_DEF0, 4'b1111, 32'h0000_009A);
      run_load("lw", LD_LW, 1'b1, 4'b1111, 5'd9, 32'h0000_3004, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
      run_load("lwl3", LD_LWL, 1'b1, 4'b1111, 5'd10, 32'h0000_3007, 32'h0102_0304, 4'b1111, 32'h0102_0304);
      run_load("lwr0", LD_LWR, 1'b1, 4'b1111, 5'd11, 32'h0000_3008, 32'h0102_0304, 4'b1111, 32'h0102_0304);
      run_load("store", LD_NONE, 1'b1, 4'b0000, 5'd0, 32'h0000_4000, 32'h7777_7777, 4'b0000, 32'h0000_4000);
      run_load("alu", LD_NONE, 1'b0, 4'b0101, 5'd12, 32'h1234_5678, 32'h0, 4'b0101, 32'h1234_5678);

      // Response arrives while WB is stalled: it must be buffered
      pc_ctr = pc_ctr + 32'd4;
      ws_allowin = 1'b0;
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = mk_es(LD_LW, 1'b1, 4'b1111, 5'd13, 32'h0000_5000, pc_ctr);
      exp_ws_q.push_back(mk_ws(4'b1111, 5'd13, 32'h5A5A_5A5A, pc_ctr));
      exp_ex_q.push_back('0);
      step();
      es_to_ms_valid = 1'b0;
      data_sram_data_ok = 1'b1;  data_sram_rdata = 32'h5A5A_5A5A;
      step();
      data_sram_data_ok = 1'b0;  data_sram_rdata = 32'hFFFF_FFFF;
      #1;
      chk("buf_valid_set", 128'(dut.r_buf_valid), 128'(1));
      chk("buf_no_pending", 128'(ms_data_pending), 128'(0));
      chk("buf_allowin_blocked", 128'(ms_allowin), 128'(0));
      step();
      ws_allowin = 1'b1;
      step();
      #1;
      chk("buf_left", 128'(ms_to_ws_valid), 128'(0));
      chk("buf_valid_clear", 128'(dut.r_buf_valid), 128'(0));

      // Flush a waiting load; its late response must be dropped
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = mk_es(LD_LW, 1'b1, 4'b1111, 5'd14, 32'h0000_6000, 32'h0000_0100);
      step();
      es_to_ms_valid = 1'b0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      #1;
      chk("cancel_inc", 128'(dut.r_cancel_cnt), 128'(1));
      chk("flush_allowin", 128'(ms_allowin), 128'(1));
      pc_ctr = pc_ctr + 32'd4;
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = mk_es(LD_LW, 1'b1, 4'b1111, 5'd15, 32'h0000_6004, pc_ctr);
      exp_ws_q.push_back(mk_ws(4'b1111, 5'd15, 32'h2222_2222, pc_ctr));
      exp_ex_q.push_back('0);
      step();
      es_to_ms_valid = 1'b0;
      data_sram_data_ok = 1'b1;  data_sram_rdata = 32'h1111_1111;
      #1;
      chk("stale_not_valid", 128'(ms_to_ws_valid), 128'(0));
      chk("stale_pending", 128'(ms_data_pending), 128'(1));
      step();
      data_sram_rdata = 32'h2222_2222;
      #1;
      chk("cancel_dec", 128'(dut.r_cancel_cnt), 128'(0));
      step();
      data_sram_data_ok = 1'b0;

      // Flush coinciding with the response: no debt recorded
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = mk_es(LD_LW, 1'b1, 4'b1111, 5'd16, 32'h0000_7000, 32'h0000_0200);
      step();
      es_to_ms_valid = 1'b0;
      data_sram_data_ok = 1'b1;  data_sram_rdata = 32'h3333_3333;
      flush = 1'b1;
      #1;
      chk("flush_ok_valid", 128'(ms_to_ws_valid), 128'(0));
      step();
      flush = 1'b0;  data_sram_data_ok = 1'b0;
      #1;
      chk("flush_ok_cnt", 128'(dut.r_cancel_cnt), 128'(0));
      chk("flush_ok_empty", 128'(ms_allowin), 128'(1));

      // Address-error store exception passes straight through
      pc_ctr = pc_ctr + 32'd4;
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = mk_es(LD_NONE, 1'b0, 4'b0000, 5'd0, 32'h0040_0003, pc_ctr);
      es_ex_bus = {10'b00_0000_0010, 5'd8, 32'h0040_0003};
      exp_ws_q.push_back(mk_ws(4'b0000, 5'd0, 32'h0040_0003, pc_ctr));
      exp_ex_q.push_back({10'b00_0000_0010, 5'd8, 32'h0040_0003});
      step();
      es_to_ms_valid = 1'b0;  es_ex_bus = '0;
      #1;
      chk("ades_ms_ex", 128'(ms_ex), 128'(1));
      chk("ades_write_reg", 128'(ms_write_reg), 128'(0));
      step();
      #1;
      chk("ades_gone", 128'(ms_ex), 128'(0));

      // Reset while a load waits with a debt outstanding
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = mk_es(LD_LW, 1'b1, 4'b1111, 5'd17, 32'h0000_8000, 32'h0000_0300);
      step();
      es_to_ms_valid = 1'b0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = mk_es(LD_LW, 1'b1, 4'b1111, 5'd18, 32'h0000_8004, 32'h0000_0304);
      step();
      es_to_ms_valid = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      chk("rst_cancel_cnt", 128'(dut.r_cancel_cnt), 128'(0));
      chk("rst_buf_valid", 128'(dut.r_buf_valid), 128'(0));
      chk("rst_to_ws_valid", 128'(ms_to_ws_valid), 128'(0));
      chk("rst_allowin", 128'(ms_allowin), 128'(1));
      chk("rst_pending", 128'(ms_data_pending), 128'(0));

      run_load("post_rst_lw", LD_LW, 1'b1, 4'b1111, 5'd19, 32'h0000_9000, 32'hCAFE_BABE, 4'b1111, 32'hCAFE_BABE);

      step();
      step();
      chk("scoreboard_drained", 128'(exp_ws_q.size()), 128'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_mem_stage
`default_nettype wire
